// File: rtl/store_buffer.sv
// Posted-write FIFO between the memory stage and data RAM, drained via req/ack.
// Optional load forwarding from queued stores is built when STORE_BUF_FWD_EN is defined.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 18,
    parameter int DW    = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          st_valid,
    input  logic [AW-1:0] st_addr,
    input  logic [DW-1:0] st_data,
    output logic          st_ready,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [AW-1:0] ld_addr,
    output logic          ld_hit,
    output logic [DW-1:0] ld_data
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          overflow_reg;
    logic          push, pop;

    assign full      = (count_reg == FULL_CNT);
    assign empty     = (count_reg == '0);
    assign st_ready  = !full;
    assign overflow  = overflow_reg;
    assign mem_req   = !empty;
    // Space is judged from the registered count only, so a same-cycle pop never admits a push while full.
    assign push      = st_valid && !full;
    assign pop       = mem_req && mem_ack;
    assign mem_addr  = empty ? '0 : addr_mem[rd_ptr_reg];
    assign mem_wdata = empty ? '0 : data_mem[rd_ptr_reg];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
            if (st_valid && full)
                overflow_reg <= 1'b1;
        end
    end

    // Entry storage is deliberately left unreset; readers mask it with empty / count.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_reg] <= st_addr;
            data_mem[wr_ptr_reg] <= st_data;
        end
    end

`ifdef STORE_BUF_FWD_EN
    logic [DEPTH-1:0] slot_hit;
    logic [DW-1:0]    slot_data [DEPTH];
    logic             ld_hit_c;
    logic [DW-1:0]    ld_data_c;

    // Slot gi is the entry gi places behind the head, so higher gi means younger.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fwd
        logic [PW-1:0] idx;
        assign idx           = rd_ptr_reg + PW'(gi);
        assign slot_hit[gi]  = (CW'(gi) < count_reg) && (addr_mem[idx] == ld_addr);
        assign slot_data[gi] = data_mem[idx];
    end

    always_comb begin
        ld_hit_c  = 1'b0;
        ld_data_c = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (slot_hit[k]) begin
                ld_hit_c  = 1'b1;
                ld_data_c = slot_data[k];
            end
        end
    end

    assign ld_hit  = ld_hit_c;
    assign ld_data = ld_data_c;
`else
    logic unused_ld_addr;
    assign unused_ld_addr = ^ld_addr;
    assign ld_hit  = 1'b0;
    assign ld_data = '0;
`endif

endmodule
